// File: rtl/cim_pkg.sv
// Shared types and helpers for the CIM crossbar tile: FSM state encoding,
// accumulator width rule and unsigned saturation.
package cim_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        SAT     = 2'd2
    } cim_tile_state_t;

    // Wide enough for xbar_size rows of full-scale inputs, so it never overflows.
    function automatic int cim_acc_width(input int xbar_size, input int datatype_size);
        return datatype_size + $clog2(xbar_size);
    endfunction

    function automatic logic [31:0] cim_sat(input logic [31:0] acc, input int datatype_size);
        logic [31:0] max_val;
        max_val = (32'd1 << datatype_size) - 32'd1;
        return (acc > max_val) ? max_val : acc;
    endfunction

endpackage

// File: rtl/cim_col_acc.sv
// One crossbar column: accumulates the selected row input each COMPUTE cycle
// and presents the saturated sum for capture into the result buffer.
module cim_col_acc
    import cim_pkg::*;
#(
    parameter int xbar_size     = 256,
    parameter int datatype_size = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic                     w_bit_i,
    input  logic [datatype_size-1:0] in_val_i,
    output logic [datatype_size-1:0] sat_o
);

    localparam int ACC_W = cim_acc_width(xbar_size, datatype_size);
    localparam int DW    = datatype_size;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i && w_bit_i) begin
            acc_d = acc_q + ACC_W'(in_val_i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign sat_o = DW'(cim_sat(32'(acc_q), datatype_size));

endmodule

// File: rtl/cim_xbar_tile.sv
// Behavioural CIM crossbar tile: 1-bit weight array times unsigned input vector,
// evaluated one row per cycle, results saturated into a registered read buffer.
module cim_xbar_tile
    import cim_pkg::*;
#(
    parameter int xbar_size     = 256,
    parameter int datatype_size = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_w_we,
    input  logic [$clog2(xbar_size)-1:0] i_w_row,
    input  logic [xbar_size-1:0]         i_w_data,
    input  logic                         i_we,
    input  logic [$clog2(xbar_size)-1:0] i_wr_addr,
    input  logic [datatype_size-1:0]     i_wr_data,
    input  logic                         i_exec,
    output logic                         o_busy,
    output logic                         o_done,
    input  logic [$clog2(xbar_size)-1:0] i_rd_addr,
    output logic [datatype_size-1:0]     o_rd_data
);

    localparam int AW = $clog2(xbar_size);
    localparam int DW = datatype_size;
    localparam logic [AW-1:0] LAST_ROW = AW'(xbar_size - 1);

    cim_tile_state_t state_q, state_d;
    logic [AW-1:0]   row_q, row_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            start;
    logic            res_we;
    logic            acc_en;
    logic            idle;

    logic [xbar_size-1:0] w_q   [xbar_size];
    logic [DW-1:0]        in_q  [xbar_size];
    logic [DW-1:0]        res_q [xbar_size];
    logic [DW-1:0]        sat   [xbar_size];
    logic [DW-1:0]        rd_data_q;

    logic [xbar_size-1:0] w_row_cur;
    logic [DW-1:0]        in_cur;

    assign idle      = (state_q == IDLE);
    assign acc_en    = (state_q == COMPUTE);
    assign w_row_cur = w_q[row_q];
    assign in_cur    = in_q[row_q];

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        start   = 1'b0;
        res_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_exec) begin
                    start   = 1'b1;
                    row_d   = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                row_d = row_q + 1'b1;
                if (row_q == LAST_ROW) begin
                    state_d = SAT;
                end
            end
            SAT: begin
                res_we  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // busy/done are registered from next state so they carry no comb path from i_exec.
        busy_d = (state_d != IDLE);
        done_d = res_we;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_data_q <= res_q[i_rd_addr];
        end
    end

    // Weight and input writes land only in IDLE; a write on the exec edge joins that MVM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < xbar_size; i++) begin
                w_q[i]  <= '0;
                in_q[i] <= '0;
            end
        end else if (idle) begin
            if (i_w_we) begin
                w_q[i_w_row] <= i_w_data;
            end
            if (i_we) begin
                in_q[i_wr_addr] <= i_wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < xbar_size; i++) begin
                res_q[i] <= '0;
            end
        end else if (res_we) begin
            for (int i = 0; i < xbar_size; i++) begin
                res_q[i] <= sat[i];
            end
        end
    end

    for (genvar c = 0; c < xbar_size; c++) begin : g_col
        cim_col_acc #(
            .xbar_size     (xbar_size),
            .datatype_size (datatype_size)
        ) u_acc (
            .clk      (clk),
            .rst      (rst),
            .clr_i    (start),
            .en_i     (acc_en),
            .w_bit_i  (w_row_cur[c]),
            .in_val_i (in_cur),
            .sat_o    (sat[c])
        );
    end

    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_rd_data = rd_data_q;

endmodule

// File: tb/tb_cim_xbar_tile.sv
// Self-checking bench for cim_xbar_tile at xbar_size=8, datatype_size=4.
module tb_cim_xbar_tile;

    localparam int N  = 8;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_w_we;
    logic [2:0]    i_w_row;
    logic [N-1:0]  i_w_data;
    logic          i_we;
    logic [2:0]    i_wr_addr;
    logic [DW-1:0] i_wr_data;
    logic          i_exec;
    logic          o_busy;
    logic          o_done;
    logic [2:0]    i_rd_addr;
    logic [DW-1:0] o_rd_data;

    int checks   = 0;
    int failures = 0;

    logic [31:0] sb[$];

    typedef struct {
        logic [63:0] w;
        logic [31:0] inv;
        logic [31:0] expv;
    } vec_t;

    vec_t tv[4];

    cim_xbar_tile #(.xbar_size(N), .datatype_size(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_w_we    (i_w_we),
        .i_w_row   (i_w_row),
        .i_w_data  (i_w_data),
        .i_we      (i_we),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .i_exec    (i_exec),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .i_rd_addr (i_rd_addr),
        .o_rd_data (o_rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (actual running, required finished)");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, expv);
        end
    endtask

    function automatic logic [31:0] model(input logic [63:0] w, input logic [31:0] inv);
        logic [31:0] r;
        r = '0;
        for (int c = 0; c < N; c++) begin
            int s;
            s = 0;
            for (int rr = 0; rr < N; rr++) begin
                if (w[8*rr + c]) s += int'(inv[4*rr +: 4]);
            end
            r[4*c +: 4] = (s > 15) ? 4'd15 : 4'(s);
        end
        return r;
    endfunction

    task automatic load(input logic [63:0] w, input logic [31:0] inv);
        for (int r = 0; r < N; r++) begin
            i_w_we    = 1'b1;
            i_w_row   = 3'(r);
            i_w_data  = w[8*r +: 8];
            i_we      = 1'b1;
            i_wr_addr = 3'(r);
            i_wr_data = inv[4*r +: 4];
            tick();
        end
        i_w_we = 1'b0;
        i_we   = 1'b0;
    endtask

    task automatic clear_inputs();
        i_w_we    = 1'b0;
        i_we      = 1'b0;
        i_exec    = 1'b0;
        i_w_row   = '0;
        i_w_data  = '0;
        i_wr_addr = '0;
        i_wr_data = '0;
    endtask

    // inject: write row0/IN0 and re-exec while busy; same_we: write IN[0]=9 on the exec edge.
    task automatic run_mvm(input logic [31:0] expv, input string tag, input bit inject, input bit same_we);
        int busy_n;
        logic [31:0] got;
        sb.push_back(expv);
        i_exec = 1'b1;
        if (same_we) begin
            i_we      = 1'b1;
            i_wr_addr = 3'd0;
            i_wr_data = 4'd9;
        end
        tick();
        clear_inputs();
        busy_n = 0;
        while (o_busy === 1'b1 && busy_n < 40) begin
            busy_n++;
            if (inject && busy_n == 2) begin
                i_we      = 1'b1;
                i_wr_addr = 3'd0;
                i_wr_data = 4'd9;
                i_w_we    = 1'b1;
                i_w_row   = 3'd1;
                i_w_data  = 8'h00;
                i_exec    = 1'b1;
            end else begin
                clear_inputs();
            end
            tick();
        end
        clear_inputs();
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'd9);
        check({tag, "_done_pulse"}, 32'(o_done), 32'd1);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_scoreboard: actual=empty required=entry", tag);
            got = '0;
        end else begin
            got = sb.pop_front();
        end
        for (int c = 0; c < N; c++) begin
            i_rd_addr = 3'(c);
            tick();
            if (c == 0) check({tag, "_done_single"}, 32'(o_done), 32'd0);
            check($sformatf("%s_col%0d", tag, c), 32'(o_rd_data), 32'(got[4*c +: 4]));
        end
    endtask

    initial begin
        rst       = 1'b0;
        i_rd_addr = '0;
        clear_inputs();

        tv[0] = '{w: 64'hFFFF_FFFF_FFFF_FFFF, inv: 32'h1111_1111, expv: 32'h8888_8888};
        tv[1] = '{w: 64'hFFFF_FFFF_FFFF_FFFF, inv: 32'hFFFF_FFFF, expv: 32'hFFFF_FFFF};
        tv[2] = '{w: 64'h8040_2010_0804_0201, inv: 32'hA987_6543, expv: 32'hA987_6543};
        tv[3].w    = {$urandom, $urandom};
        tv[3].inv  = $urandom;
        tv[3].expv = model(tv[3].w, tv[3].inv);

        #3;
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_rd_data", 32'(o_rd_data), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        i_rd_addr = 3'd5;
        tick();
        check("rst_read_col5", 32'(o_rd_data), 32'd0);

        // W and IN cleared by reset, so an MVM straight away yields zeros.
        run_mvm(32'h0, "zero", 1'b0, 1'b0);

        for (int v = 0; v < 4; v++) begin
            load(tv[v].w, tv[v].inv);
            run_mvm(tv[v].expv, $sformatf("vec%0d", v), 1'b0, 1'b0);
        end

        load(64'h8040_2010_0804_0201, 32'hA987_6543);
        run_mvm(32'hA987_6543, "busy_drop", 1'b1, 1'b0);
        check("busy_no_restart", 32'(o_busy), 32'd0);
        run_mvm(32'hA987_6549, "same_edge", 1'b0, 1'b1);

        // Reset in the middle of COMPUTE.
        i_exec = 1'b1;
        tick();
        i_exec = 1'b0;
        repeat (4) tick();
        check("mid_busy_before", 32'(o_busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        check("mid_rst_done", 32'(o_done), 32'd0);
        check("mid_rst_rd_data", 32'(o_rd_data), 32'd0);
        for (int k = 0; k < 12; k++) begin
            if (k == 2) rst = 1'b1;
            i_rd_addr = 3'd7;
            tick();
            check($sformatf("mid_no_done_%0d", k), 32'(o_done), 32'd0);
        end
        check("mid_busy_after", 32'(o_busy), 32'd0);
        check("mid_res_col7", 32'(o_rd_data), 32'd0);

        load(tv[0].w, tv[0].inv);
        run_mvm(tv[0].expv, "fresh", 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cim_xbar_tile.md
# cim_xbar_tile

Behavioural crossbar tile that sits on the far side of a layer's CIM interface and answers it. It accepts row inputs from a conv or fc layer controller, runs a bit-cell matrix-vector multiply row-serially while holding busy, and returns per-column results through a registered read port. A layer instantiates one tile per (vertical, horizontal) tile position. The tile is used in simulation and in performance and area estimates.

## Interface
- `xbar_size`, default 256: rows = columns; must be a power of two ≥ 2.
- `datatype_size`, default 4: input and output element width.
- `clk` input, 1 bit: clock; every register uses the rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `i_w_we` input, 1 bit: weight row write strobe.
- `i_w_row` input, `$clog2(xbar_size)` bits: weight row address.
- `i_w_data` input, `xbar_size` bits: one row of 1-bit cells; bit c is column c.
- `i_we` input, 1 bit: input-buffer write strobe.
- `i_wr_addr` input, `$clog2(xbar_size)` bits: input row address. The layer drives this from its CIM write address.
- `i_wr_data` input, `datatype_size` bits: input value, unsigned.
- `i_exec` input, 1 bit: start MVM.
- `o_busy` output, 1 bit: MVM in progress. The layer samples this as its CIM busy input.
- `o_done` output, 1 bit: one-cycle pulse when results are valid.
- `i_rd_addr` input, `$clog2(xbar_size)` bits: result column address.
- `o_rd_data` output, `datatype_size` bits: registered column result.

## Operation
- Storage:
  - weight array W[row][col], 1 bit per cell;
  - input buffer IN[row], `datatype_size` bits;
  - accumulators ACC[col], `datatype_size+$clog2(xbar_size)` bits;
  - result buffer RES[col], `datatype_size` bits.
- FSM states IDLE, COMPUTE, SAT.
  - IDLE → COMPUTE on `i_exec`. The row counter clears to 0 and all ACC clear to 0.
  - In COMPUTE, each cycle: ACC[c] += W[r][c] ? IN[r] : 0 for every c, then r++.
  - After r = xbar_size-1, go COMPUTE → SAT.
  - In SAT: RES[c] = min(ACC[c], 2^datatype_size-1), i.e. unsigned saturation. Pulse `o_done`, then go SAT → IDLE.
- Writes to W and IN are accepted only in IDLE. While not in IDLE, `i_w_we` and `i_we` are ignored (dropped, not queued).
- `i_exec` is ignored outside IDLE.
- If `i_we`/`i_w_we` and `i_exec` are sampled on the same IDLE edge, the write commits and is included in that MVM.
- Reads are legal in any state.
  - `o_rd_data` = RES[`i_rd_addr`], registered.
  - During an MVM, RES holds the previous MVM's values until the SAT edge.
- Reset values: `o_busy`=0, `o_done`=0, `o_rd_data`=0, state IDLE, row counter 0, IN/ACC/RES all 0.
- W is cleared on reset. For large `xbar_size` this is permitted as a behavioural model.
- Reset asserted mid-MVM aborts immediately to the reset values above. No `o_done` is produced.

## Timing
- `i_exec` sampled at edge E0.
  - `o_busy`=1 from E0 through edge E0+xbar_size+1, where it falls. It is high for exactly xbar_size+1 cycles.
  - `o_done`=1 in the cycle after edge E0+xbar_size+1, coincident with `o_busy` falling.
- `o_busy` is registered and derived from state ≠ IDLE. There is no combinational path from `i_exec`.
- A new `i_exec` is accepted in the cycle `o_busy` reads 0, so back-to-back MVMs run xbar_size+2 cycles apart.
- Read latency is 1 cycle: an address sampled at edge N gives data valid after N.
- A read of column c issued in the `o_done` cycle returns the new RES[c].
- ACC width never overflows: the maximum sum is xbar_size·(2^datatype_size-1).

## Structure
- Shared package `cim_pkg` holds:
  - the state enum `cim_tile_state_t` (IDLE, COMPUTE, SAT);
  - the function `cim_acc_width(xbar_size, datatype_size)`;
  - the saturation function `cim_sat`.
- One sub-module, `cim_col_acc`: one column accumulator plus saturation, generated xbar_size times.
- The top level holds the FSM, row counter, W, IN and RES.

## Test plan
Tests use `xbar_size`=8 and `datatype_size`=4 unless noted.
- **Reset:** pulse `rst` low mid-cycle → all outputs 0 asynchronously, and a read of any column returns 0.
- **All-ones MVM:** W all 1, IN all 1, `i_exec` → `o_busy` high exactly 9 cycles, `o_done` single pulse, every column reads 8.
- **Saturation:** W all 1, IN all 15 (sum 120) → every column reads 15.
- **Identity:** W[r][c]=(r==c), IN[r]=r+3 → column c reads min(c+3, 15); column 7 reads 10.
- **Busy and same-edge rules:**
  - `i_we` to row 0 (value 9) and a second `i_exec` during COMPUTE → both ignored, and the result uses the old IN.
  - A same-edge `i_we`+`i_exec` in IDLE → the written value is included.
- **Mid-MVM reset:** `rst` low at cycle 4 of COMPUTE → `o_busy` drops immediately, no `o_done`, RES reads 0. A fresh MVM after release completes normally.
